// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM state encoding and
// the program start-address table.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam logic [15:0] PROG0_ADDR = 16'h0000;
  localparam logic [15:0] PROG1_ADDR = 16'h0100;
  localparam logic [15:0] PROG2_ADDR = 16'h0200;

  // Select 3 is reserved and falls back to program 0's address.
  function automatic logic [15:0] start_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    start_addr = PROG1_ADDR;
      2'd2:    start_addr = PROG2_ADDR;
      default: start_addr = PROG0_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and enable; sticks at all ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == {W{1'b1}});
  assign o_count  = r_count;

  always_ff @(posedge clk) begin
    if (srst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: sequences the fetch unit through IDLE/INIT/RUN/DONE per start
// request. Optional watchdog compiled in with RUN_CTRL_WATCHDOG_EN.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                INIT_CYCLES = 2,
  parameter int                CNT_W       = 16,
  parameter logic [CNT_W-1:0]  MAX_CYCLES  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             HaltOp,
  output logic             PcInit,
  output logic             PcHalt,
  output logic [15:0]      StartAddr,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic             Timeout
);

  run_state_t r_state, w_state_next;
  logic [3:0] r_init_cnt, w_init_cnt_next;
  logic [1:0] r_sel, w_sel_next;
  logic       w_accept;
  logic       w_run_en;

  // Start is only honoured when no run is in flight.
  assign w_accept = Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_run_en = (r_state == RUN);

  assign PcInit    = (r_state == INIT);
  assign PcHalt    = (r_state != RUN);
  assign Busy      = (r_state == INIT) || (r_state == RUN);
  assign Done      = (r_state == DONE);
  assign StartAddr = start_addr(r_sel);

`ifdef RUN_CTRL_WATCHDOG_EN
  logic r_timeout, w_timeout_next;
  logic w_wd_hit;

  // Fires on the RUN cycle whose increment brings the count to MAX_CYCLES.
  assign w_wd_hit = (CycleCount >= (MAX_CYCLES - 1'b1));
  assign Timeout  = r_timeout;
`else
  logic w_unused_max;

  assign w_unused_max = ^MAX_CYCLES;
  assign Timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_init_cnt <= 4'd0;
      r_sel      <= 2'd0;
`ifdef RUN_CTRL_WATCHDOG_EN
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_init_cnt <= w_init_cnt_next;
      r_sel      <= w_sel_next;
`ifdef RUN_CTRL_WATCHDOG_EN
      r_timeout  <= w_timeout_next;
`endif
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_init_cnt_next = r_init_cnt;
    w_sel_next      = r_sel;
`ifdef RUN_CTRL_WATCHDOG_EN
    w_timeout_next  = r_timeout;
`endif
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_next    = INIT;
          w_init_cnt_next = 4'(INIT_CYCLES);
          w_sel_next      = ProgSel;
`ifdef RUN_CTRL_WATCHDOG_EN
          w_timeout_next  = 1'b0;
`endif
        end
      end
      INIT: begin
        w_init_cnt_next = r_init_cnt - 4'd1;
        if (r_init_cnt <= 4'd1) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (HaltOp) begin
          w_state_next = DONE;
        end
`ifdef RUN_CTRL_WATCHDOG_EN
        else if (w_wd_hit) begin
          w_state_next   = DONE;
          w_timeout_next = 1'b1;
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk     (clk),
    .srst    (Reset),
    .i_clr   (w_accept),
    .i_en    (w_run_en),
    .o_count (CycleCount)
  );

endmodule
